// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: sequences an external 4-bit adder slice over WIDTH-bit operands, LS nibble first; `SUB_EN adds a sub port for x - y
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
`ifdef SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [3:0]       ax,
  output logic [3:0]       ay,
  output logic             acin,
  input  logic [3:0]       as,
  input  logic             acout
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] xr, yr;
  logic carry;
  logic [WIDTH-1:0] y_in;
  logic c_in;
`ifdef SUB_EN
  // subtraction is x + ~y + 1; cout high means no borrow
  assign y_in = sub ? ~y : y;
  assign c_in = sub | cin;
`else
  assign y_in = y;
  assign c_in = cin;
`endif
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    ax   = state == RUN ? xr[4*idx +: 4] : 4'd0;
    ay   = state == RUN ? yr[4*idx +: 4] : 4'd0;
    acin = state == RUN ? carry : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      xr    <= '0;
      yr    <= '0;
      carry <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        xr    <= x;
        yr    <= y_in;
        carry <= c_in;
        idx   <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      s[4*idx +: 4] <= as;
      carry <= acout;
      idx   <= idx + 1'b1;
      if (idx == LAST) begin
        cout  <= acout;
        state <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed vectors with a scoreboard queue checked on each done pulse
module tb_nibble_serial_add_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [15:0] x = '0, y = '0, s;
  logic busy, done, cout, acin, acout;
  logic [3:0] ax, ay, as;
  logic [16:0] q[$];
  int total = 0, bad = 0, dones = 0;
  always #5 clk = ~clk;
  assign {acout, as} = 5'(ax) + 5'(ay) + 5'(acin);
  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .cin(cin),
`ifdef SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .s(s), .cout(cout),
    .ax(ax), .ay(ay), .acin(acin), .as(as), .acout(acout)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done) begin
      dones++;
      if (q.size() == 0) chk("unexpected done", 32'd1, 32'd0);
      else chk("sum", 32'({cout, s}), 32'(q.pop_front()));
    end
  end
  task automatic go(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb,
                    input logic [16:0] e, input bit push);
    @(negedge clk);
    x = a; y = b; cin = c; sub = sb; start = 1'b1;
    if (push) q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    if (busy) chk("idle timeout", 32'd1, 32'd0);
  endtask
  logic [3:0] exp_ax[4] = '{4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] exp_ay[4] = '{4'h1, 4'h2, 4'h3, 4'h4};
  logic exp_c[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  initial begin
    int d0;
    #12;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset s", 32'(s), 0);
    chk("reset cout", 32'(cout), 0);
    chk("reset ax", 32'(ax), 0);
    @(negedge clk) rst_n = 1'b1;
    // 1: basic add with nibble sequence and latency
    go(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h0_5555, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("t1 busy", 32'(busy), 1);
      chk("t1 done early", 32'(done), 0);
      chk("t1 ax", 32'(ax), 32'(exp_ax[k]));
      chk("t1 ay", 32'(ay), 32'(exp_ay[k]));
      @(posedge clk);
      #1;
    end
    chk("t1 done", 32'(done), 1);
    chk("t1 ax idle", 32'(ax), 0);
    @(posedge clk);
    #1;
    chk("t1 done drop", 32'(done), 0);
    chk("t1 busy drop", 32'(busy), 0);
    // 2: carry ripple across all nibbles
    go(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("t2 acin", 32'(acin), 32'(exp_c[k]));
      @(posedge clk);
      #1;
    end
    wait_idle();
    go(16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h1_0000, 1'b1);
    wait_idle();
    // 3: start while busy is ignored
    d0 = dones;
    go(16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h0_0100, 1'b1);
    @(posedge clk);
    #1 x = 16'h1111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1 chk("t3 one done", 32'(dones - d0), 1);
    // 4: reset mid-operation
    d0 = dones;
    go(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t4 busy", 32'(busy), 0);
    chk("t4 s", 32'(s), 0);
    chk("t4 cout", 32'(cout), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("t4 no done", 32'(dones - d0), 0);
    go(16'h0001, 16'h0002, 1'b0, 1'b0, 17'h0_0003, 1'b1);
    wait_idle();
    // 5: input changes after acceptance, result holds
    go(16'h1F0F, 16'h2101, 1'b1, 1'b0, 17'h0_4011, 1'b1);
    x = 16'hFFFF; y = 16'hFFFF; cin = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("t5 s hold", 32'(s), 32'h4011);
    chk("t5 cout hold", 32'(cout), 0);
`ifdef SUB_EN
    // 6: subtraction
    go(16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0_FFFE, 1'b1);
    wait_idle();
    go(16'h0007, 16'h0005, 1'b0, 1'b1, 17'h1_0002, 1'b1);
    wait_idle();
`endif
    repeat (2) @(posedge clk);
    chk("queue drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
